// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH stages of {valid, ctrl, rd_addr, data} with stall, flush,
// optional bubble collapsing, occupancy count and a forwarding-enable flag for hazard logic.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CTRL_W   = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 1,
    parameter int unsigned COLLAPSE = 0,
    parameter int unsigned FW_BIT   = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         full_o,
    output logic                         valid_o,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [ADDR_W-1:0]            rd_addr_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         fwd_en_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  hold;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [OCC_W-1:0]  occ;

    // Hold chain, walked from the output stage back towards the input.
    always_comb begin : hold_chain
        logic run;
        hold           = '0;
        run            = stall_i;
        hold[DEPTH-1]  = stall_i;
        for (int j = int'(DEPTH) - 2; j >= 0; j--) begin
            if (COLLAPSE != 0) begin
                run = run & valid_q[j+1];
            end else begin
                run = stall_i;
            end
            hold[j] = run;
        end
    end

    // A stage takes its predecessor whenever the predecessor moves on; a held-but-overtaken
    // slot (only possible when it is empty) becomes a bubble, so no entry is ever dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ctrl_q[k] <= '0;
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ctrl_q[k] <= '0;
            end
        end else begin
            if (!hold[0]) begin
                valid_q[0] <= valid_i;
                ctrl_q[0]  <= valid_i ? ctrl_i : '0;
                addr_q[0]  <= rd_addr_i;
                data_q[0]  <= data_i;
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (!hold[k-1]) begin
                    valid_q[k] <= valid_q[k-1];
                    ctrl_q[k]  <= ctrl_q[k-1];
                    addr_q[k]  <= addr_q[k-1];
                    data_q[k]  <= data_q[k-1];
                end else if (!hold[k]) begin
                    valid_q[k] <= 1'b0;
                    ctrl_q[k]  <= '0;
                end
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ = occ + OCC_W'(valid_q[k]);
        end
    end

    assign full_o      = hold[0] & ~flush_i;
    assign valid_o     = valid_q[DEPTH-1];
    assign ctrl_o      = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
    assign rd_addr_o   = addr_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];
    assign fwd_en_o    = valid_o & ctrl_o[FW_BIT] & (rd_addr_o != '0);
    assign occupancy_o = occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations (1-stage, 3-stage frozen, 3-stage collapsing)
// driven in parallel and checked against a slot-array reference model.
module tb_pipe_stage_reg;

    logic        clk, rst, stall, flush, vin;
    logic [3:0]  cin;
    logic [4:0]  rin;
    logic [31:0] din;

    logic        o_full [3];
    logic        o_valid[3];
    logic        o_fwd  [3];
    logic [3:0]  o_ctrl [3];
    logic [4:0]  o_rd   [3];
    logic [31:0] o_data [3];
    logic [0:0]  occ_a;
    logic [1:0]  occ_b, occ_c;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.DEPTH(1), .COLLAPSE(0)) u_d1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .ctrl_i(cin), .rd_addr_i(rin), .data_i(din), .full_o(o_full[0]), .valid_o(o_valid[0]),
        .ctrl_o(o_ctrl[0]), .rd_addr_o(o_rd[0]), .data_o(o_data[0]), .fwd_en_o(o_fwd[0]),
        .occupancy_o(occ_a));

    pipe_stage_reg #(.DEPTH(3), .COLLAPSE(0)) u_d3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .ctrl_i(cin), .rd_addr_i(rin), .data_i(din), .full_o(o_full[1]), .valid_o(o_valid[1]),
        .ctrl_o(o_ctrl[1]), .rd_addr_o(o_rd[1]), .data_o(o_data[1]), .fwd_en_o(o_fwd[1]),
        .occupancy_o(occ_b));

    pipe_stage_reg #(.DEPTH(3), .COLLAPSE(1)) u_c3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .ctrl_i(cin), .rd_addr_i(rin), .data_i(din), .full_o(o_full[2]), .valid_o(o_valid[2]),
        .ctrl_o(o_ctrl[2]), .rd_addr_o(o_rd[2]), .data_o(o_data[2]), .fwd_en_o(o_fwd[2]),
        .occupancy_o(occ_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: per configuration, an array of slots (index 0 = input side).
    int          dep[3] = '{1, 3, 3};
    bit          col[3] = '{0, 0, 1};
    bit          mv[3][3];
    logic [3:0]  mc[3][3];
    logic [4:0]  mr[3][3];
    logic [31:0] md[3][3];

    function automatic void m_reset();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mv[i][j] = 1'b0; mc[i][j] = '0; mr[i][j] = '0; md[i][j] = '0;
            end
    endfunction

    // Slot that the next edge frees up: the output when running; when stalled and collapsing,
    // the highest bubble above stage 0; otherwise none (-1).
    function automatic int m_gap(int i);
        int b;
        if (!stall) return dep[i] - 1;
        if (!col[i]) return -1;
        b = -1;
        for (int j = 0; j < dep[i]; j++) if (!mv[i][j]) b = j;
        return (b >= 1) ? b : -1;
    endfunction

    function automatic bit m_full(int i);
        if (flush) return 1'b0;
        return m_gap(i) < 0;
    endfunction

    function automatic void m_step();
        int b;
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                for (int j = 0; j < dep[i]; j++) begin mv[i][j] = 1'b0; mc[i][j] = '0; end
            end else begin
                b = m_gap(i);
                if (b >= 0) begin
                    for (int j = b; j >= 1; j--) begin
                        mv[i][j] = mv[i][j-1]; mc[i][j] = mc[i][j-1];
                        mr[i][j] = mr[i][j-1]; md[i][j] = md[i][j-1];
                    end
                    mv[i][0] = vin; mc[i][0] = cin; mr[i][0] = rin; md[i][0] = din;
                end
            end
        end
    endfunction

    function automatic bit e_valid(int i);
        return mv[i][dep[i]-1];
    endfunction

    function automatic logic [3:0] e_ctrl(int i);
        return e_valid(i) ? mc[i][dep[i]-1] : 4'h0;
    endfunction

    function automatic bit e_fwd(int i);
        logic [3:0] c;
        c = e_ctrl(i);
        return e_valid(i) && c[0] && (mr[i][dep[i]-1] != 5'd0);
    endfunction

    function automatic int e_occ(int i);
        int n = 0;
        for (int j = 0; j < dep[i]; j++) n += int'(mv[i][j]);
        return n;
    endfunction

    function automatic int get_occ(int i);
        case (i)
            0:       return int'(occ_a);
            1:       return int'(occ_b);
            default: return int'(occ_c);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) m_reset(); else m_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; vin = 1'b0; cin = '0; rin = '0; din = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        m_reset();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (o_valid[i] !== 1'b0) begin bad++; $display("FAIL rst_valid[%0d]: got %0b want 0", i, o_valid[i]); end
            total++; if (o_ctrl[i] !== 4'h0) begin bad++; $display("FAIL rst_ctrl[%0d]: got %0h want 0", i, o_ctrl[i]); end
            total++; if (o_rd[i] !== 5'h0) begin bad++; $display("FAIL rst_rd[%0d]: got %0h want 0", i, o_rd[i]); end
            total++; if (o_data[i] !== 32'h0) begin bad++; $display("FAIL rst_data[%0d]: got %0h want 0", i, o_data[i]); end
            total++; if (o_fwd[i] !== 1'b0) begin bad++; $display("FAIL rst_fwd[%0d]: got %0b want 0", i, o_fwd[i]); end
            total++; if (o_full[i] !== 1'b0) begin bad++; $display("FAIL rst_full[%0d]: got %0b want 0", i, o_full[i]); end
            total++; if (get_occ(i) != 0) begin bad++; $display("FAIL rst_occ[%0d]: got %0d want 0", i, get_occ(i)); end
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        vin = 1'b1; cin = 4'b0011; rin = 5'd5; din = 32'hDEAD_BEEF;
        #1;
        total++; if (o_full[0] !== 1'b0) begin bad++; $display("FAIL single_full: got %0b want 0", o_full[0]); end
        tick();
        total++; if (o_valid[0] !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", o_valid[0]); end
        total++; if (o_ctrl[0] !== 4'b0011) begin bad++; $display("FAIL single_ctrl: got %0h want 3", o_ctrl[0]); end
        total++; if (o_rd[0] !== 5'd5) begin bad++; $display("FAIL single_rd: got %0d want 5", o_rd[0]); end
        total++; if (o_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data: got %0h want deadbeef", o_data[0]); end
        total++; if (o_fwd[0] !== 1'b1) begin bad++; $display("FAIL single_fwd: got %0b want 1", o_fwd[0]); end
        total++; if (occ_a !== 1'b1) begin bad++; $display("FAIL single_occ: got %0d want 1", occ_a); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vin = 1'b1; cin = 4'($urandom); rin = 5'($urandom); din = $urandom;
            #1;
            total++; if (o_full[0] !== 1'b1) begin bad++; $display("FAIL stall_full[%0d]: got %0b want 1", c, o_full[0]); end
            tick();
            total++; if (o_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stall_data[%0d]: got %0h want deadbeef", c, o_data[0]); end
            total++; if (o_valid[0] !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %0b want 1", c, o_valid[0]); end
        end
        stall = 1'b0; vin = 1'b1; cin = 4'hA; rin = 5'd7; din = 32'h1234_5678;
        tick();
        total++; if (o_data[0] !== 32'h1234_5678) begin bad++; $display("FAIL unstall_data: got %0h want 12345678", o_data[0]); end
        total++; if (o_rd[0] !== 5'd7) begin bad++; $display("FAIL unstall_rd: got %0d want 7", o_rd[0]); end
    endtask

    task automatic test_chain();
        logic [31:0] pat [3];
        pat[0] = 32'hAAAA_0001; pat[1] = 32'hBBBB_0002; pat[2] = 32'hCCCC_0003;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vin = 1'b1; cin = 4'h1; rin = 5'(c + 1); din = pat[c];
            tick();
        end
        stall = 1'b1; vin = 1'b1; din = 32'hDDDD_0004;
        #1;
        total++; if (o_full[1] !== 1'b1) begin bad++; $display("FAIL chain_full: got %0b want 1", o_full[1]); end
        tick();
        total++; if (occ_b !== 2'd3) begin bad++; $display("FAIL chain_occ: got %0d want 3", occ_b); end
        total++; if (o_data[1] !== pat[0]) begin bad++; $display("FAIL chain_frozen: got %0h want %0h", o_data[1], pat[0]); end
        stall = 1'b0; vin = 1'b0;
        for (int c = 1; c < 3; c++) begin
            tick();
            total++; if (o_data[1] !== pat[c] || o_valid[1] !== 1'b1) begin
                bad++; $display("FAIL chain_order[%0d]: got %0h/%0b want %0h/1", c, o_data[1], o_valid[1], pat[c]);
            end
        end
        tick();
        total++; if (o_valid[1] !== 1'b0) begin bad++; $display("FAIL chain_drain: got %0b want 0", o_valid[1]); end
    endtask

    task automatic test_collapse();
        flush = 1'b1; tick(); flush = 1'b0;
        vin = 1'b1; cin = 4'h1; rin = 5'd3; din = 32'hA0A0_A0A0; tick();
        vin = 1'b0; tick();
        vin = 1'b1; rin = 5'd4; din = 32'hB0B0_B0B0; tick();
        total++; if (occ_c !== 2'd2) begin bad++; $display("FAIL coll_occ_pre: got %0d want 2", occ_c); end
        stall = 1'b1; vin = 1'b1; rin = 5'd6; din = 32'hC0C0_C0C0;
        #1;
        total++; if (o_full[2] !== 1'b0) begin bad++; $display("FAIL coll_full_first: got %0b want 0", o_full[2]); end
        tick();
        total++; if (occ_c !== 2'd3) begin bad++; $display("FAIL coll_occ_post: got %0d want 3", occ_c); end
        total++; if (o_data[2] !== 32'hA0A0_A0A0) begin bad++; $display("FAIL coll_out_held: got %0h want a0a0a0a0", o_data[2]); end
        #1;
        total++; if (o_full[2] !== 1'b1) begin bad++; $display("FAIL coll_full_second: got %0b want 1", o_full[2]); end
    endtask

    task automatic test_flush();
        stall = 1'b1; flush = 1'b1; vin = 1'b1; cin = 4'hF; rin = 5'd9;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (o_full[i] !== 1'b0) begin bad++; $display("FAIL flush_full[%0d]: got %0b want 0", i, o_full[i]); end
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_fwd[i] !== 1'b0 || get_occ(i) != 0) begin
                bad++; $display("FAIL flush_out[%0d]: got v=%0b c=%0h f=%0b o=%0d want all 0", i, o_valid[i], o_ctrl[i], o_fwd[i], get_occ(i));
            end
        end
        idle_inputs();
    endtask

    task automatic test_xdata();
        vin = 1'b0; cin = 'x; rin = 'x; din = 'x;
        tick();
        total++; if (o_ctrl[0] !== 4'h0) begin bad++; $display("FAIL xdata_ctrl: got %0h want 0", o_ctrl[0]); end
        total++; if (o_fwd[0] !== 1'b0) begin bad++; $display("FAIL xdata_fwd: got %0b want 0", o_fwd[0]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(19) == 0);
            vin   = ($urandom_range(2) != 0);
            cin   = 4'($urandom);
            rin   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            din   = $urandom;
            #1;
            for (int i = 0; i < 3; i++) begin
                total++; if (o_full[i] !== m_full(i)) begin bad++; $display("FAIL rnd_full[%0d] n=%0d: got %0b want %0b", i, n, o_full[i], m_full(i)); end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                total++; if (o_valid[i] !== e_valid(i)) begin bad++; $display("FAIL rnd_valid[%0d] n=%0d: got %0b want %0b", i, n, o_valid[i], e_valid(i)); end
                total++; if (o_ctrl[i] !== e_ctrl(i)) begin bad++; $display("FAIL rnd_ctrl[%0d] n=%0d: got %0h want %0h", i, n, o_ctrl[i], e_ctrl(i)); end
                total++; if (o_fwd[i] !== e_fwd(i)) begin bad++; $display("FAIL rnd_fwd[%0d] n=%0d: got %0b want %0b", i, n, o_fwd[i], e_fwd(i)); end
                total++; if (get_occ(i) != e_occ(i)) begin bad++; $display("FAIL rnd_occ[%0d] n=%0d: got %0d want %0d", i, n, get_occ(i), e_occ(i)); end
                if (e_valid(i)) begin
                    total++; if (o_rd[i] !== mr[i][dep[i]-1] || o_data[i] !== md[i][dep[i]-1]) begin
                        bad++; $display("FAIL rnd_payload[%0d] n=%0d: got %0h/%0h want %0h/%0h", i, n, o_rd[i], o_data[i], mr[i][dep[i]-1], md[i][dep[i]-1]);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        vin = 1'b1; cin = 4'b0001; rin = 5'd0; din = 32'hCAFE_0000;
        tick();
        total++; if (o_valid[0] !== 1'b1 || o_fwd[0] !== 1'b0) begin
            bad++; $display("FAIL rd0_fwd: got v=%0b f=%0b want v=1 f=0", o_valid[0], o_fwd[0]);
        end
        rin = 5'd9; din = 32'hCAFE_0001;
        tick();
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (o_valid[i] !== 1'b0 || o_ctrl[i] !== 4'h0 || o_rd[i] !== 5'h0 || o_data[i] !== 32'h0 || o_fwd[i] !== 1'b0 || get_occ(i) != 0) begin
                bad++; $display("FAIL async_rst[%0d]: got v=%0b c=%0h r=%0h d=%0h f=%0b o=%0d want all 0",
                                i, o_valid[i], o_ctrl[i], o_rd[i], o_data[i], o_fwd[i], get_occ(i));
            end
        end
        m_reset();
        tick();
        rst = 1'b1; vin = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (o_valid[i] !== 1'b0) begin bad++; $display("FAIL post_rst_valid[%0d]: got %0b want 0", i, o_valid[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_chain();
        test_collapse();
        test_flush();
        test_xdata();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
